// File: rtl/aes_spi_master_pkg.sv
// Shared definitions for the AES SPI master/slave pair: FSM states,
// block width, mode-pin encoding and counter sizing helper.
package aes_spi_pkg;

  localparam int   AES_BLOCK_W = 128;
  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_READ   = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_MSG = 3'd1,
    SEND_KEY = 3'd2,
    WAIT     = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Bits needed to hold 0..max_val, never less than one so a zero-length
  // wait still has a legal counter.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_spi_master_if.sv
// Host/link bundle of the AES SPI master: parallel request side plus the
// serial SIMO/SOMI/mode link towards the slave.
interface aes_spi_master_if #(
  parameter int DATA_W = aes_spi_pkg::AES_BLOCK_W
);
  logic              start;
  logic [DATA_W-1:0] msg;
  logic [DATA_W-1:0] key;
  logic              SOMI;
  logic              SIMO;
  logic              mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    input  start, msg, key, SOMI,
    output SIMO, mode, busy, done, result
  );

  modport slave (
    output start, msg, key, SOMI,
    input  SIMO, mode, busy, done, result
  );
endinterface

// File: rtl/aes_spi_master_shift_reg.sv
// LSB-first shift register. Shifts right, new serial data enters at the MSB,
// serial output is bit 0. Only the low TAP_W bits are exported: the transmit
// path needs just the serial bit, the receive path needs the whole word.
module spi_shift_reg #(
  parameter int DATA_W = 128,
  parameter int TAP_W  = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_shift_en,
  input  logic              i_sin,
  output logic [TAP_W-1:0]  o_data
);

  logic [DATA_W-1:0] r_data;

  // Parallel load has priority over shifting so a reload can replace the
  // word on the same edge its last bit leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {DATA_W{1'b0}};
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift_en) begin
      r_data <= {i_sin, r_data[DATA_W-1:1]};
    end else begin
      r_data <= r_data;
    end
  end

  assign o_data = r_data[TAP_W-1:0];

endmodule

// File: rtl/aes_spi_master.sv
// Serial master for the AES SPI slave: streams plaintext then key out on
// SIMO (LSB first), waits READ_WAIT cycles for the AES core, raises mode and
// shifts the ciphertext back in from SOMI. One transaction per start.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int READ_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_spi_master_if.master bus
);

  localparam int                CNT_W     = $clog2(DATA_W);
  localparam int                WAIT_W    = cnt_width(READ_WAIT);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

  state_e              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]   r_key_hold;
  logic [DATA_W-1:0]   r_result;
  logic                r_simo;
  logic                r_mode;
  logic                r_busy;
  logic                r_done;

  logic                w_tx_load;
  logic [DATA_W-1:0]   w_tx_load_data;
  logic                w_tx_shift;
  logic                w_tx_bit;
  logic                w_rx_load;
  logic                w_rx_shift;
  logic [DATA_W-1:0]   w_rx_data;

  // Shift-register control decoded from the current state: load msg on an
  // accepted start, swap in the held key as the last msg bit goes out.
  always_comb begin
    w_tx_load      = 1'b0;
    w_tx_load_data = bus.msg;
    w_tx_shift     = 1'b0;
    w_rx_load      = 1'b0;
    w_rx_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_load      = bus.start;
        w_tx_load_data = bus.msg;
        w_rx_load      = bus.start;
      end
      SEND_MSG: begin
        w_tx_shift = 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_tx_load      = 1'b1;
          w_tx_load_data = r_key_hold;
        end else begin
          w_tx_load      = 1'b0;
          w_tx_load_data = bus.msg;
        end
      end
      SEND_KEY: begin
        w_tx_shift = 1'b1;
      end
      RECV: begin
        w_rx_shift = 1'b1;
      end
      default: begin
        w_tx_shift = 1'b0;
      end
    endcase
  end

  spi_shift_reg #(
    .DATA_W (DATA_W),
    .TAP_W  (1)
  ) u_tx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_tx_load),
    .i_load_data (w_tx_load_data),
    .i_shift_en  (w_tx_shift),
    .i_sin       (1'b0),
    .o_data      (w_tx_bit)
  );

  spi_shift_reg #(
    .DATA_W (DATA_W),
    .TAP_W  (DATA_W)
  ) u_rx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_rx_load),
    .i_load_data ({DATA_W{1'b0}}),
    .i_shift_en  (w_rx_shift),
    .i_sin       (bus.SOMI),
    .o_data      (w_rx_data)
  );

  // Transaction sequencer: state, bit/wait counters and all registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_wait_cnt <= {WAIT_W{1'b0}};
      r_key_hold <= {DATA_W{1'b0}};
      r_result   <= {DATA_W{1'b0}};
      r_simo     <= 1'b0;
      r_mode     <= MODE_LOAD;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_simo <= 1'b0;
          r_mode <= MODE_LOAD;
          if (bus.start) begin
            r_key_hold <= bus.key;
            r_bit_cnt  <= {CNT_W{1'b0}};
            r_wait_cnt <= {WAIT_W{1'b0}};
            r_busy     <= 1'b1;
            r_state    <= SEND_MSG;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SEND_MSG: begin
          r_simo    <= w_tx_bit;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= SEND_KEY;
          end else begin
            r_state <= SEND_MSG;
          end
        end
        SEND_KEY: begin
          r_simo    <= w_tx_bit;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
            r_state    <= WAIT;
          end else begin
            r_state <= SEND_KEY;
          end
        end
        WAIT: begin
          r_simo <= 1'b0;
          // The exit edge raises mode, so READ_WAIT=0 still leaves mode low
          // for the cycle that carries the last key bit.
          if (r_wait_cnt == WAIT_LAST) begin
            r_mode    <= MODE_READ;
            r_bit_cnt <= {CNT_W{1'b0}};
            r_state   <= RECV;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        RECV: begin
          r_simo    <= 1'b0;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= DONE;
          end else begin
            r_state <= RECV;
          end
        end
        DONE: begin
          r_result <= w_rx_data;
          r_done   <= 1'b1;
          r_mode   <= MODE_LOAD;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_simo  <= 1'b0;
          r_mode  <= MODE_LOAD;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.SIMO   = r_simo;
  assign bus.mode   = r_mode;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: two instances (READ_WAIT=64 and READ_WAIT=0)
// sharing stimulus, a behavioural slave driving SOMI, and a cycle-indexed
// reference of the transaction timeline.
module tb_aes_spi_master;

  localparam int W    = 128;
  localparam int RW_A = 64;
  localparam logic [W-1:0] FIPS_MSG = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [W-1:0] RB_WORD  = 128'h0123456789abcdef0011223344556677;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic         r_start;
  logic         r_somi;
  logic [W-1:0] r_msg;
  logic [W-1:0] r_key;

  logic         w_simo;
  logic         w_mode;
  logic         w_busy;
  logic         w_done;
  logic [W-1:0] w_result;

  logic [W-1:0] prev_a;
  logic [W-1:0] prev_b;
  logic [W-1:0] got;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_spi_master_if #(.DATA_W(W)) u_if_a ();
  aes_spi_master_if #(.DATA_W(W)) u_if_b ();

  assign u_if_a.start = r_start & ~sel;
  assign u_if_b.start = r_start & sel;
  assign u_if_a.msg   = r_msg;
  assign u_if_b.msg   = r_msg;
  assign u_if_a.key   = r_key;
  assign u_if_b.key   = r_key;
  assign u_if_a.SOMI  = r_somi;
  assign u_if_b.SOMI  = r_somi;

  assign w_simo   = sel ? u_if_b.SIMO   : u_if_a.SIMO;
  assign w_mode   = sel ? u_if_b.mode   : u_if_a.mode;
  assign w_busy   = sel ? u_if_b.busy   : u_if_a.busy;
  assign w_done   = sel ? u_if_b.done   : u_if_a.done;
  assign w_result = sel ? u_if_b.result : u_if_a.result;

  aes_spi_master #(.DATA_W(W), .READ_WAIT(RW_A)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_a.master)
  );

  aes_spi_master #(.DATA_W(W), .READ_WAIT(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_b.master)
  );

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Slave's AES core: knows the FIPS-197 pair, otherwise returns the
  // response word chosen by the test.
  function automatic logic [W-1:0] slave_reply(input logic [W-1:0] m,
                                               input logic [W-1:0] k,
                                               input logic [W-1:0] dflt);
    if (m == FIPS_MSG && k == FIPS_KEY) begin
      return FIPS_CT;
    end
    return dflt;
  endfunction

  task automatic chk_val(input string tag, input logic [2*W-1:0] got_v,
                         input logic [2*W-1:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got_v, exp_v);
    end
  endtask

  // One transaction on the selected instance. Cycle c counts posedges after
  // the edge that accepts start; expected pin values follow from c alone.
  task automatic run_txn(input string tag, input logic [W-1:0] m,
                         input logic [W-1:0] k, input logic [W-1:0] dflt,
                         input bit hammer, input logic [W-1:0] prev,
                         output logic [W-1:0] got_r);
    int rw, lat, idx;
    int e_busy, e_done, e_mode, e_simo, e_hold;
    logic [2*W-1:0] stream;
    logic [W-1:0]   resp;
    rw     = sel ? 0 : RW_A;
    lat    = 3 * W + rw + 2;
    idx    = 0;
    e_busy = 0; e_done = 0; e_mode = 0; e_simo = 0; e_hold = 0;
    stream = '0;
    resp   = dflt;
    got_r  = '0;
    @(negedge clk);
    r_start = 1'b1;
    r_msg   = m;
    r_key   = k;
    r_somi  = 1'($urandom);
    for (int c = 0; c <= lat; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1 && c <= 2 * W) stream[c-1] = w_simo;
      else if (w_simo !== 1'b0) e_simo++;
      if (w_busy !== (c < lat)) e_busy++;
      if (w_done !== (c == lat)) e_done++;
      if (w_mode !== (c >= 2 * W + 1 + rw && c < lat)) e_mode++;
      if (c < lat && w_result !== prev) e_hold++;
      if (c == 2 * W) resp = slave_reply(stream[W-1:0], stream[2*W-1:W], dflt);
      if (c == lat) got_r = w_result;
      if (c < lat) begin
        @(negedge clk);
        r_start = hammer;
        r_msg   = rand_word();
        r_key   = rand_word();
        if (w_mode && idx < W) begin
          r_somi = resp[idx];
          idx++;
        end else begin
          r_somi = 1'($urandom);
        end
      end
    end
    r_start = 1'b0;
    chk_val({tag, "/simo_stream"}, stream, {k, m});
    chk_val({tag, "/simo_idle_errs"}, 256'(e_simo), 256'd0);
    chk_val({tag, "/busy_errs"}, 256'(e_busy), 256'd0);
    chk_val({tag, "/done_errs"}, 256'(e_done), 256'd0);
    chk_val({tag, "/mode_errs"}, 256'(e_mode), 256'd0);
    chk_val({tag, "/result_hold_errs"}, 256'(e_hold), 256'd0);
    chk_val({tag, "/result"}, {{W{1'b0}}, got_r}, {{W{1'b0}}, slave_reply(m, k, dflt)});
  endtask

  initial begin
    int e;
    total   = 0;
    bad     = 0;
    sel     = 1'b0;
    r_start = 1'b0;
    r_somi  = 1'b0;
    r_msg   = '0;
    r_key   = '0;
    rst_n   = 1'b0;
    prev_a  = '0;
    prev_b  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_a/outputs", {124'd0, w_simo, w_mode, w_busy, w_done, w_result}, 256'd0);
    sel = 1'b1;
    #1;
    chk_val("reset_b/outputs", {124'd0, w_simo, w_mode, w_busy, w_done, w_result}, 256'd0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_txn("fips_a", FIPS_MSG, FIPS_KEY, rand_word(), 1'b0, prev_a, got);
    prev_a = got;
    repeat (2) @(posedge clk);
    run_txn("readback", rand_word(), rand_word(), RB_WORD, 1'b0, prev_a, got);
    prev_a = got;
    // Start lands the cycle right after done.
    run_txn("back2back", rand_word(), rand_word(), rand_word(), 1'b0, prev_a, got);
    prev_a = got;
    repeat (2) @(posedge clk);
    run_txn("hammer", rand_word(), rand_word(), rand_word(), 1'b1, prev_a, got);
    prev_a = got;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_val("hammer/idle_after", {254'd0, w_busy, w_done}, 256'd0);
    end

    // Abort in the middle of the key stream.
    @(negedge clk);
    r_start = 1'b1;
    r_msg   = rand_word();
    r_key   = rand_word();
    @(posedge clk);
    #1;
    r_start = 1'b0;
    repeat (199) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("abort/outputs", {124'd0, w_simo, w_mode, w_busy, w_done, w_result}, 256'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 450; i++) begin
      @(posedge clk);
      #1;
      if (w_done !== 1'b0 || w_busy !== 1'b0) e++;
    end
    chk_val("abort/no_done", 256'(e), 256'd0);
    prev_a = '0;
    run_txn("restart", rand_word(), rand_word(), rand_word(), 1'b0, prev_a, got);
    prev_a = got;

    sel = 1'b1;
    repeat (2) @(posedge clk);
    run_txn("fips_rw0", FIPS_MSG, FIPS_KEY, rand_word(), 1'b0, prev_b, got);
    prev_b = got;
    run_txn("rand_rw0", rand_word(), rand_word(), rand_word(), 1'b0, prev_b, got);
    prev_b = got;

    sel = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      run_txn("rand_a", rand_word(), rand_word(), rand_word(), 1'b0, prev_a, got);
      prev_a = got;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
